// File: rtl/address_fsm.sv
// Read-address generator: expands one micro-instruction (start address, length)
// into a burst of consecutive read addresses over a valid/ready channel.
package config_pkg;
  typedef logic [31:0] addr_t;
  localparam int unsigned LEN_W = 8;
  typedef struct packed {
    logic [7:0]       code;
    addr_t            addr;
    logic [LEN_W-1:0] len;
  } uinstr_t;
endpackage

module address_fsm
  import config_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = $bits(addr_t),
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic    clk_i,
  input  logic    arst_ni,
  input  uinstr_t uinstr_i,
  input  logic    uinstr_valid_i,
  output logic    uinstr_ready_o,
  output addr_t   rd_addr_o,
  output logic    rd_addr_valid_o,
  input  logic    rd_addr_ready_i
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  logic [0:0]            state_r;
  logic [0:0]            state_s;
  logic [ADDR_WIDTH-1:0] cur_addr_r;
  logic [ADDR_WIDTH-1:0] cur_addr_s;
  logic [LEN_WIDTH-1:0]  remaining_r;
  logic [LEN_WIDTH-1:0]  remaining_s;
  logic [LEN_WIDTH-1:0]  len_s;
  logic                  unused_code_s;

  assign len_s         = LEN_WIDTH'(uinstr_i.len);
  assign unused_code_s = ^uinstr_i.code;

  // Next-state and datapath update; only the accepting edge samples uinstr_i.
  always_comb begin
    state_s     = state_r;
    cur_addr_s  = cur_addr_r;
    remaining_s = remaining_r;
    case (state_r)
      ST_IDLE: begin
        if (uinstr_valid_i) begin
          cur_addr_s  = ADDR_WIDTH'(uinstr_i.addr);
          remaining_s = len_s;
          if (len_s != {LEN_WIDTH{1'b0}}) begin
            state_s = ST_ISSUE;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (rd_addr_ready_i) begin
          // Address wraps modulo 2^ADDR_WIDTH and the burst carries on.
          cur_addr_s  = cur_addr_r + ADDR_WIDTH'(1);
          remaining_s = remaining_r - LEN_WIDTH'(1);
          if (remaining_r == LEN_WIDTH'(1)) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_ISSUE;
          end
        end else begin
          state_s = ST_ISSUE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and burst registers; reset aborts any burst in flight.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_r     <= ST_IDLE;
      cur_addr_r  <= {ADDR_WIDTH{1'b0}};
      remaining_r <= {LEN_WIDTH{1'b0}};
    end else begin
      state_r     <= state_s;
      cur_addr_r  <= cur_addr_s;
      remaining_r <= remaining_s;
    end
  end

  // Handshake outputs decode the state register only, so no input reaches an output.
  assign uinstr_ready_o  = (state_r == ST_IDLE);
  assign rd_addr_valid_o = (state_r == ST_ISSUE);
  assign rd_addr_o       = addr_t'(cur_addr_r);

endmodule

// File: tb/tb_address_fsm.sv
// Directed bench for address_fsm: expected addresses are queued when an instruction
// is driven and popped by a monitor on every address handshake.
module tb_address_fsm;
  import config_pkg::*;

  logic    clk = 1'b0;
  logic    arst_ni;
  uinstr_t uinstr;
  logic    uinstr_valid;
  logic    uinstr_ready;
  addr_t   rd_addr;
  logic    rd_addr_valid;
  logic    rd_addr_ready;

  int n_asserts = 0;
  int n_fails   = 0;
  int issued    = 0;
  int pushed    = 0;
  logic [31:0] exp_q[$];

  address_fsm dut (
    .clk_i          (clk),
    .arst_ni        (arst_ni),
    .uinstr_i       (uinstr),
    .uinstr_valid_i (uinstr_valid),
    .uinstr_ready_o (uinstr_ready),
    .rd_addr_o      (rd_addr),
    .rd_addr_valid_o(rd_addr_valid),
    .rd_addr_ready_i(rd_addr_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [7:0] l);
    uinstr.code  = 8'($urandom);
    uinstr.addr  = a;
    uinstr.len   = l;
    uinstr_valid = 1'b1;
    for (int i = 0; i < int'(l); i++) exp_q.push_back(a + 32'(i));
    pushed += int'(l);
  endtask

  // Mid-cycle monitor: a handshake seen here completes on the next rising edge.
  always @(negedge clk) begin
    if (rd_addr_valid === 1'b1 && rd_addr_ready === 1'b1) begin
      issued++;
      if (exp_q.size() == 0) begin
        n_asserts++;
        n_fails++;
        $error("FAIL spurious_addr: observed %h expected no address", rd_addr);
      end else begin
        chk("rd_addr", rd_addr, exp_q.pop_front());
      end
    end
  end

  initial begin
    int base;
    int cyc;
    int l;
    arst_ni       = 1'b0;
    uinstr        = '0;
    uinstr_valid  = 1'b0;
    rd_addr_ready = 1'b0;

    // Reset state is visible before any clock edge.
    #3;
    chk("rst_ready", 32'(uinstr_ready), 32'd1);
    chk("rst_valid", 32'(rd_addr_valid), 32'd0);
    chk("rst_addr", rd_addr, 32'h0);
    @(posedge clk); #1;
    arst_ni = 1'b1;
    @(posedge clk); #1;

    // Basic burst with constant ready.
    rd_addr_ready = 1'b1;
    drive(32'h100, 8'd3);
    @(posedge clk); #1;
    uinstr_valid = 1'b0;
    uinstr.addr  = 32'hDEAD_BEEF;
    uinstr.len   = 8'd7;
    chk("busy_ready", 32'(uinstr_ready), 32'd0);
    chk("first_valid", 32'(rd_addr_valid), 32'd1);
    chk("first_addr", rd_addr, 32'h100);
    repeat (3) @(posedge clk);
    #1;
    chk("basic_done_ready", 32'(uinstr_ready), 32'd1);
    chk("basic_done_valid", 32'(rd_addr_valid), 32'd0);
    chk("basic_q_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure: address and valid hold while ready is low.
    rd_addr_ready = 1'b0;
    drive(32'h20, 8'd2);
    @(posedge clk); #1;
    uinstr_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(rd_addr_valid), 32'd1);
      chk("bp_addr", rd_addr, 32'h20);
      @(posedge clk); #1;
    end
    base = issued;
    rd_addr_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("bp_count", 32'(issued - base), 32'd2);
    chk("bp_done_ready", 32'(uinstr_ready), 32'd1);
    chk("bp_done_valid", 32'(rd_addr_valid), 32'd0);

    // Address wrap.
    drive(32'hFFFF_FFFF, 8'd2);
    @(posedge clk); #1;
    uinstr_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("wrap_done_valid", 32'(rd_addr_valid), 32'd0);
    chk("wrap_q_empty", 32'(exp_q.size()), 32'd0);

    // Empty burst: consumed, nothing issued, ready stays high.
    base = issued;
    drive(32'h300, 8'd0);
    @(posedge clk); #1;
    uinstr_valid = 1'b0;
    chk("empty_ready", 32'(uinstr_ready), 32'd1);
    chk("empty_valid", 32'(rd_addr_valid), 32'd0);
    chk("empty_addr", rd_addr, 32'h300);
    @(posedge clk); #1;
    chk("empty_count", 32'(issued - base), 32'd0);

    // Back-to-back random instructions with valid held high.
    base = issued;
    pushed = 0;
    cyc = 0;
    while (cyc < 35) begin
      l = int'($urandom_range(0, 5));
      drive($urandom, 8'(l));
      repeat (l + 1) @(posedge clk);
      #1;
      cyc += l + 1;
    end
    uinstr_valid = 1'b0;
    chk("rand_count", 32'(issued - base), 32'(pushed));
    chk("rand_ready", 32'(uinstr_ready), 32'd1);
    chk("rand_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a burst.
    base = issued;
    drive(32'h500, 8'd10);
    @(posedge clk); #1;
    uinstr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    arst_ni = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rd_addr_valid), 32'd0);
    chk("mid_rst_ready", 32'(uinstr_ready), 32'd1);
    chk("mid_rst_addr", rd_addr, 32'h0);
    chk("mid_rst_count", 32'(issued - base), 32'd3);
    exp_q.delete();
    @(posedge clk); #1;
    arst_ni = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", 32'(rd_addr_valid), 32'd0);
    base = issued;
    drive(32'h600, 8'd2);
    @(posedge clk); #1;
    uinstr_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_count", 32'(issued - base), 32'd2);
    chk("final_q_empty", 32'(exp_q.size()), 32'd0);
    chk("final_ready", 32'(uinstr_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
